multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decoder.sv | 61 ++++++
 rtl/multicycle_control_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// decoded instruction classes, opcode values and ALU operation codes.
// Ports: none (package).
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ADDI    = 3'd2,
    CLS_LW      = 3'd3,
    CLS_SW      = 3'd4,
    CLS_BEQ     = 3'd5,
    CLS_HALT    = 3'd6
  } op_class_e;

  // Opcode values in their minimum 4-bit form; zero-extended at use.
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd3;
  localparam logic [3:0] OP_SW    = 4'd11;
  localparam logic [3:0] OP_BEQ   = 4'd12;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // ALU operation codes in their minimum 2-bit form; zero-extended at use.
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // MEM-state cycle counter width; covers timeouts up to 255.
  localparam int unsigned MEM_CNT_W = 8;

  // Instruction classes that spend time in the MEM state.
  function automatic logic is_mem_class(input op_class_e cls);
    return (cls == CLS_LW) || (cls == CLS_SW);
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational opcode-to-control lookup.
// Ports:
//   opcode_i    - opcode to decode (upper bits beyond 4 must be zero to match)
//   op_class_o  - instruction class; CLS_ILLEGAL for any unlisted opcode
//   regdst_o, alusrc_o, memreg_o - datapath selects for this opcode
//   aluop_o     - ALU operation for this opcode
module ctrl_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_e           op_class_o,
  output logic                regdst_o,
  output logic                alusrc_o,
  output logic                memreg_o,
  output logic [ALUOP_W-1:0]  aluop_o
);

  // Opcode lookup; unlisted opcodes are illegal with every select low.
  always_comb begin
    op_class_o = CLS_ILLEGAL;
    regdst_o   = 1'b0;
    alusrc_o   = 1'b0;
    memreg_o   = 1'b0;
    aluop_o    = ALUOP_W'(ALU_ADD);
    case (opcode_i)
      OPCODE_W'(OP_RTYPE): begin
        op_class_o = CLS_RTYPE;
        regdst_o   = 1'b1;
        aluop_o    = ALUOP_W'(ALU_FUNCT);
      end
      OPCODE_W'(OP_ADDI): begin
        op_class_o = CLS_ADDI;
        alusrc_o   = 1'b1;
      end
      OPCODE_W'(OP_LW): begin
        op_class_o = CLS_LW;
        alusrc_o   = 1'b1;
        memreg_o   = 1'b1;
      end
      OPCODE_W'(OP_SW): begin
        // regdst/memreg are don't-care for stores; driven low.
        op_class_o = CLS_SW;
        alusrc_o   = 1'b1;
      end
      OPCODE_W'(OP_BEQ): begin
        op_class_o = CLS_BEQ;
        aluop_o    = ALUOP_W'(ALU_SUB);
      end
      OPCODE_W'(OP_HALT): begin
        op_class_o = CLS_HALT;
      end
      default: begin
        op_class_o = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB).
// Level outputs (instr_ready, busy, selects, aluop, memread, memwrite) are
// registered from the next state so they line up with the state they belong
// to. Event pulses (done, regwrite, branch, illegal, mem_err) are registered
// from the transition out of the current state and appear in the following
// cycle.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   instr_valid, opcode  - instruction offer; accepted when instr_ready is high
//   instr_ready          - high only in IDLE
//   zero                 - ALU zero flag, sampled in EXEC
//   mem_ack              - data memory completion, honoured only in MEM
//   regdst/alusrc/memreg - datapath selects, DECODE through instruction end
//   aluop                - ALU operation, DECODE through instruction end
//   memread/memwrite     - held high in every MEM cycle of LW/SW
//   regwrite, branch     - one-cycle strobes
//   done/illegal/mem_err - one-cycle completion / fault pulses
//   busy                 - high outside IDLE and HALT
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                regdst,
  output logic                alusrc,
  output logic                memreg,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic                branch,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                done,
  output logic                illegal,
  output logic                mem_err,
  output logic                busy
);

  localparam logic [MEM_CNT_W-1:0] TIMEOUT_C = MEM_CNT_W'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [MEM_CNT_W-1:0]  cnt_q, cnt_d;

  logic                  instr_ready_q, instr_ready_d;
  logic                  busy_q, busy_d;
  logic                  regdst_q, regdst_d;
  logic                  alusrc_q, alusrc_d;
  logic                  memreg_q, memreg_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic                  memread_q, memread_d;
  logic                  memwrite_q, memwrite_d;
  logic                  regwrite_q, regwrite_d;
  logic                  branch_q, branch_d;
  logic                  done_q, done_d;
  logic                  illegal_q, illegal_d;
  logic                  mem_err_q, mem_err_d;

  logic                  accept_s;
  logic                  sel_active_s;
  logic [OPCODE_W-1:0]   dec_opcode_s;
  op_class_e             cls_s;
  logic                  dec_regdst_s;
  logic                  dec_alusrc_s;
  logic                  dec_memreg_s;
  logic [ALUOP_W-1:0]    dec_aluop_s;

  assign accept_s = instr_valid & instr_ready_q;

  // On accept the decoder looks at the incoming opcode so the selects are
  // already valid in DECODE; otherwise it reflects the latched opcode.
  assign dec_opcode_s = accept_s ? opcode : opcode_q;

  ctrl_decoder #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decoder (
    .opcode_i   (dec_opcode_s),
    .op_class_o (cls_s),
    .regdst_o   (dec_regdst_s),
    .alusrc_o   (dec_alusrc_s),
    .memreg_o   (dec_memreg_s),
    .aluop_o    (dec_aluop_s)
  );

  // Next-state, MEM counter and next-output computation.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    mem_err_d  = 1'b0;
    regwrite_d = 1'b0;
    branch_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_DECODE;
          opcode_d = opcode;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CLS_HALT: begin
            state_d = ST_HALT;
          end
          CLS_ILLEGAL: begin
            state_d   = ST_IDLE;
            illegal_d = 1'b1;
          end
          default: begin
            state_d = ST_EXEC;
          end
        endcase
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_RTYPE, CLS_ADDI: begin
            state_d = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            state_d = ST_MEM;
            cnt_d   = MEM_CNT_W'(1);
          end
          CLS_BEQ: begin
            state_d  = ST_IDLE;
            branch_d = zero;
            done_d   = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_MEM: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (mem_ack) begin
          cnt_d = '0;
          if (cls_s == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + MEM_CNT_W'(1);
        end
      end
      ST_WB: begin
        state_d    = ST_IDLE;
        regwrite_d = 1'b1;
        done_d     = 1'b1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    instr_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_HALT);
    sel_active_s  = state_d inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
    regdst_d      = sel_active_s & dec_regdst_s;
    alusrc_d      = sel_active_s & dec_alusrc_s;
    memreg_d      = sel_active_s & dec_memreg_s;
    aluop_d       = sel_active_s ? dec_aluop_s : '0;
    memread_d     = (state_d == ST_MEM) && is_mem_class(cls_s) && (cls_s == CLS_LW);
    memwrite_d    = (state_d == ST_MEM) && is_mem_class(cls_s) && (cls_s == CLS_SW);
  end

  // State, latched opcode, MEM counter and all output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      cnt_q         <= '0;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      regdst_q      <= 1'b0;
      alusrc_q      <= 1'b0;
      memreg_q      <= 1'b0;
      aluop_q       <= '0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      regwrite_q    <= 1'b0;
      branch_q      <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      cnt_q         <= cnt_d;
      instr_ready_q <= instr_ready_d;
      busy_q        <= busy_d;
      regdst_q      <= regdst_d;
      alusrc_q      <= alusrc_d;
      memreg_q      <= memreg_d;
      aluop_q       <= aluop_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      regwrite_q    <= regwrite_d;
      branch_q      <= branch_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign busy        = busy_q;
  assign regdst      = regdst_q;
  assign alusrc      = alusrc_q;
  assign memreg      = memreg_q;
  assign aluop       = aluop_q;
  assign memread     = memread_q;
  assign memwrite    = memwrite_q;
  assign regwrite    = regwrite_q;
  assign branch      = branch_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit. Each vector holds the
// inputs for one clock cycle and the complete output word expected after
// that cycle's rising edge. Inputs change and outputs are sampled on the
// falling edge. A hand-written sequence covers asynchronous reset mid-MEM.
// Output word: {ready,busy, regdst,alusrc,memreg, regwrite,memread,memwrite,
//               branch, done,illegal,mem_err, aluop[2:0]}
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       instr_ready, regdst, alusrc, memreg, regwrite, memread, memwrite;
  logic       branch, done, illegal, mem_err, busy;
  logic [2:0] aluop;
  logic [14:0] outs_s;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W    (4),
    .ALUOP_W     (3),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .instr_ready (instr_ready),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .regdst      (regdst),
    .alusrc      (alusrc),
    .memreg      (memreg),
    .regwrite    (regwrite),
    .memread     (memread),
    .memwrite    (memwrite),
    .branch      (branch),
    .aluop       (aluop),
    .done        (done),
    .illegal     (illegal),
    .mem_err     (mem_err),
    .busy        (busy)
  );

  assign outs_s = {instr_ready, busy, regdst, alusrc, memreg, regwrite, memread,
                   memwrite, branch, done, illegal, mem_err, aluop};

  //                                      RB_DAM_WRWB_DIE_AAA
  localparam logic [14:0] O_IDLE   = 15'b10_000_0000_000_000;
  localparam logic [14:0] O_HALT   = 15'b00_000_0000_000_000;
  localparam logic [14:0] O_WBDONE = 15'b10_000_1000_100_000;
  localparam logic [14:0] O_DONE   = 15'b10_000_0000_100_000;
  localparam logic [14:0] O_BR     = 15'b10_000_0001_100_000;
  localparam logic [14:0] O_ILL    = 15'b10_000_0000_010_000;
  localparam logic [14:0] O_MERR   = 15'b10_000_0000_001_000;
  localparam logic [14:0] O_R      = 15'b01_100_0000_000_010;
  localparam logic [14:0] O_ADDI   = 15'b01_010_0000_000_000;
  localparam logic [14:0] O_SW     = 15'b01_010_0000_000_000;
  localparam logic [14:0] O_SWM    = 15'b01_010_0010_000_000;
  localparam logic [14:0] O_LW     = 15'b01_011_0000_000_000;
  localparam logic [14:0] O_LWM    = 15'b01_011_0100_000_000;
  localparam logic [14:0] O_BEQ    = 15'b01_000_0000_000_001;
  localparam logic [14:0] O_DEC0   = 15'b01_000_0000_000_000;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [3:0]  op;
    logic        zero;
    logic        ack;
    logic [14:0] exp;
  } vec_t;

  vec_t  tv[$];
  string tags[$];

  task automatic add(input logic r, input logic v, input logic [3:0] op,
                     input logic z, input logic a, input logic [14:0] e,
                     input string t);
    vec_t x;
    x.rst = r; x.valid = v; x.op = op; x.zero = z; x.ack = a; x.exp = e;
    tv.push_back(x);
    tags.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic z, input logic a);
    rst = r; instr_valid = v; opcode = op; zero = z; mem_ack = a;
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // reset state
    add(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, O_IDLE, "reset0");
    add(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, O_IDLE, "reset1");
    // RTYPE: opcode changes while busy must be ignored
    add(1'b0, 1'b1, 4'd0,  1'b0, 1'b0, O_R,      "rtype_dec");
    add(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, O_R,      "rtype_exec");
    add(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, O_R,      "rtype_wb");
    add(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, O_WBDONE, "rtype_done");
    // ADDI accepted back-to-back in the done cycle
    add(1'b0, 1'b1, 4'd1,  1'b0, 1'b0, O_ADDI,   "addi_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_ADDI,   "addi_exec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_ADDI,   "addi_wb");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_WBDONE, "addi_done");
    // LW: ack outside MEM ignored; ack in 3rd MEM cycle
    add(1'b0, 1'b1, 4'd3,  1'b0, 1'b0, O_LW,     "lw_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, O_LW,     "lw_exec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, O_LWM,    "lw_mem1");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_LWM,    "lw_mem2");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_LWM,    "lw_mem3");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, O_LW,     "lw_wb");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_WBDONE, "lw_done");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, O_IDLE,   "idle_ack_ignored");
    // BEQ zero=1 then zero=0
    add(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, O_BEQ,    "beq1_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_BEQ,    "beq1_exec");
    add(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, O_BR,     "beq1_done");
    add(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, O_IDLE,   "beq1_after");
    add(1'b0, 1'b1, 4'd12, 1'b1, 1'b0, O_BEQ,    "beq0_dec");
    add(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, O_BEQ,    "beq0_exec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_DONE,   "beq0_done");
    // illegal opcodes
    add(1'b0, 1'b1, 4'd5,  1'b0, 1'b0, O_DEC0,   "ill5_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_ILL,    "ill5_pulse");
    add(1'b0, 1'b1, 4'd2,  1'b0, 1'b0, O_DEC0,   "ill2_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_ILL,    "ill2_pulse");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_IDLE,   "ill_after");
    // SW with ack in the first MEM cycle
    add(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, O_SW,     "sw1_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_SW,     "sw1_exec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_SWM,    "sw1_mem");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, O_DONE,   "sw1_done");
    // SW timeout: 15 MEM cycles, then mem_err and no done
    add(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, O_SW,     "swto_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_SW,     "swto_exec");
    for (int i = 0; i < 15; i++) add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, O_SWM, "swto_mem");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_MERR,   "swto_err");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_IDLE,   "swto_after");
    // SW with ack in the very cycle the count reaches the timeout
    add(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, O_SW,     "sw15_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_SW,     "sw15_exec");
    for (int i = 0; i < 15; i++) add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, O_SWM, "sw15_mem");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, O_DONE,   "sw15_done");
    // HALT holds until reset; new instruction in first cycle rst is low
    add(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, O_DEC0,   "halt_dec");
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, O_HALT, "halt_hold");
    add(1'b1, 1'b1, 4'd1,  1'b0, 1'b0, O_IDLE,   "halt_rst");
    add(1'b0, 1'b1, 4'd1,  1'b0, 1'b0, O_ADDI,   "post_rst_dec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_ADDI,   "post_rst_exec");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_ADDI,   "post_rst_wb");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_WBDONE, "post_rst_done");
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, O_IDLE,   "post_rst_idle");

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].valid, tv[i].op, tv[i].zero, tv[i].ack);
      @(negedge clk);
      chk(tags[i], outs_s, tv[i].exp);
    end

    // Reset asserted mid-MEM of a store: memwrite must drop without a clock.
    drive(1'b0, 1'b1, 4'd11, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rstmem_dec", outs_s, O_SW);
    @(negedge clk);
    @(negedge clk);
    chk("rstmem_mem1", outs_s, O_SWM);
    @(negedge clk);
    chk("rstmem_mem2", outs_s, O_SWM);
    #2 rst = 1'b1;
    #1;
    chk_bit("rstmem_async_memwrite", memwrite, 1'b0);
    chk_bit("rstmem_async_ready", instr_ready, 1'b1);
    chk_bit("rstmem_async_busy", busy, 1'b0);
    @(negedge clk);
    chk("rstmem_held", outs_s, O_IDLE);
    drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rstmem_addi_dec", outs_s, O_ADDI);
    @(negedge clk);
    chk("rstmem_addi_exec", outs_s, O_ADDI);
    @(negedge clk);
    chk("rstmem_addi_wb", outs_s, O_ADDI);
    @(negedge clk);
    chk("rstmem_addi_done", outs_s, O_WBDONE);
    @(negedge clk);
    chk("rstmem_idle", outs_s, O_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
